// File: rtl/fetch_pc_predictor_if.sv
// Fetch-stage PC predictor signal bundle: pipeline/hazard inputs plus the
// selected fetch PC, predPC and return-address-stack status outputs.
interface fetch_pc_predictor_if #(
    parameter int PC_WIDTH  = 64,
    parameter int RAS_PTR_W = 3
);
    logic                 f_stall_i;
    logic                 f_valid_i;
    logic [3:0]           f_icode_i;
    logic [PC_WIDTH-1:0]  f_valC_i;
    logic [PC_WIDTH-1:0]  f_valP_i;
    logic [3:0]           M_icode_i;
    logic                 M_Cnd_i;
    logic [PC_WIDTH-1:0]  M_valA_i;
    logic [3:0]           W_icode_i;
    logic [PC_WIDTH-1:0]  W_valM_i;
    logic                 W_ret_redirect_i;
    logic [PC_WIDTH-1:0]  f_pc_o;
    logic [PC_WIDTH-1:0]  predPC_o;
    logic                 ret_pred_valid_o;
    logic [RAS_PTR_W:0]   ras_count_o;
    logic                 ras_overflow_o;

    // Pipeline / hazard-unit side
    modport master (
        output f_stall_i, f_valid_i, f_icode_i, f_valC_i, f_valP_i,
        output M_icode_i, M_Cnd_i, M_valA_i, W_icode_i, W_valM_i, W_ret_redirect_i,
        input  f_pc_o, predPC_o, ret_pred_valid_o, ras_count_o, ras_overflow_o
    );

    // Predictor side
    modport slave (
        input  f_stall_i, f_valid_i, f_icode_i, f_valC_i, f_valP_i,
        input  M_icode_i, M_Cnd_i, M_valA_i, W_icode_i, W_valM_i, W_ret_redirect_i,
        output f_pc_o, predPC_o, ret_pred_valid_o, ras_count_o, ras_overflow_o
    );
endinterface

// File: rtl/fetch_pc_predictor.sv
// Y86-64 fetch-stage PC unit: owns predPC, selects the fetch PC among
// predPC / jXX mispredict / RET redirect, and predicts RET targets with a
// circular return-address stack.
module fetch_pc_predictor #(
    parameter int PC_WIDTH  = 64,
    parameter int RAS_DEPTH = 8,
    parameter int RAS_PTR_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    fetch_pc_predictor_if.slave   bus
);
    localparam int CNT_W = RAS_PTR_W + 1;
    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;
    localparam logic [CNT_W-1:0]     RAS_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [RAS_PTR_W-1:0] PTR_ONE  = RAS_PTR_W'(1);

    logic [PC_WIDTH-1:0]  pred_pc_reg;
    logic [RAS_PTR_W-1:0] top_ptr_reg;    // next free slot; top entry sits one below
    logic [CNT_W-1:0]     count_reg;
    logic                 overflow_reg;
    logic [PC_WIDTH-1:0]  ras_mem [RAS_DEPTH];

    logic                 jxx_mispredict;
    logic                 ret_redirect;
    logic [PC_WIDTH-1:0]  f_pc;
    logic [PC_WIDTH-1:0]  pred_pc_next;
    logic [PC_WIDTH-1:0]  ras_top;
    logic                 ras_nonempty;
    logic                 ras_full;
    logic                 ret_pred_valid;
    logic                 push_en;
    logic                 pop_en;

    // Fetch PC selection, next-PC prediction and RAS push/pop decisions
    always_comb begin
        jxx_mispredict = (bus.M_icode_i == IJXX) && !bus.M_Cnd_i;
        ret_redirect   = (bus.W_icode_i == IRET) && bus.W_ret_redirect_i;
        ras_top        = ras_mem[top_ptr_reg - PTR_ONE];
        ras_nonempty   = (count_reg != '0);
        ras_full       = (count_reg == RAS_FULL);

        if (jxx_mispredict)
            f_pc = bus.M_valA_i;
        else if (ret_redirect)
            f_pc = bus.W_valM_i;
        else
            f_pc = pred_pc_reg;

        ret_pred_valid = 1'b0;
        case (bus.f_icode_i)
            ICALL, IJXX: pred_pc_next = bus.f_valC_i;
            IRET: begin
                if (ras_nonempty) begin
                    pred_pc_next   = ras_top;
                    ret_pred_valid = 1'b1;
                end else begin
                    // No prediction available; the W-stage redirect repairs this
                    pred_pc_next = bus.f_valP_i;
                end
            end
            IHALT:   pred_pc_next = f_pc;
            default: pred_pc_next = bus.f_valP_i;
        endcase

        push_en = !bus.f_stall_i && bus.f_valid_i && !ret_redirect
                  && (bus.f_icode_i == ICALL);
        pop_en  = !bus.f_stall_i && bus.f_valid_i && !ret_redirect
                  && (bus.f_icode_i == IRET) && ras_nonempty;
    end

    // predPC register: follow the prediction, or capture a redirect on bubbles
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            pred_pc_reg <= '0;
        else if (!bus.f_stall_i)
            pred_pc_reg <= bus.f_valid_i ? pred_pc_next : f_pc;
    end

    // RAS pointer, occupancy and sticky overflow; a RET redirect flushes the stack
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            top_ptr_reg  <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (ret_redirect) begin
            top_ptr_reg <= '0;
            count_reg   <= '0;
        end else if (push_en) begin
            top_ptr_reg <= top_ptr_reg + PTR_ONE;
            if (ras_full)
                overflow_reg <= 1'b1;    // oldest entry was overwritten
            else
                count_reg <= count_reg + CNT_ONE;
        end else if (pop_en) begin
            top_ptr_reg <= top_ptr_reg - PTR_ONE;
            count_reg   <= count_reg - CNT_ONE;
        end
    end

    // RAS storage: write the return address into the free slot on a push
    always_ff @(posedge clk_i) begin
        if (push_en)
            ras_mem[top_ptr_reg] <= bus.f_valP_i;
    end

    assign bus.f_pc_o           = f_pc;
    assign bus.predPC_o         = pred_pc_reg;
    assign bus.ret_pred_valid_o = ret_pred_valid;
    assign bus.ras_count_o      = count_reg;
    assign bus.ras_overflow_o   = overflow_reg;
endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Testbench for fetch_pc_predictor: directed vector table, hand-written
// corner sequences and randomized stimulus against a queue-based model.
module tb_fetch_pc_predictor;
    localparam int PCW   = 64;
    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] IOPQ  = 4'h6;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_pc_predictor_if #(.PC_WIDTH(PCW), .RAS_PTR_W(PW)) bus ();

    fetch_pc_predictor #(.PC_WIDTH(PCW), .RAS_DEPTH(DEPTH), .RAS_PTR_W(PW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        bit          rst_n;
        bit          stall;
        bit          valid;
        logic [3:0]  icode;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [3:0]  m_icode;
        bit          m_cnd;
        logic [63:0] m_vala;
        logic [3:0]  w_icode;
        logic [63:0] w_valm;
        bit          w_redir;
        bit          has_exp;
        bit          chk_comb;
        logic [63:0] exp_fpc;
        bit          exp_rpv;
        logic [63:0] exp_pred;
        int          exp_cnt;
        bit          exp_ovf;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: predPC value, return stack as a bounded queue
    logic [63:0] m_pred;
    logic [63:0] m_ras [$];
    bit          m_ovf;
    bit          m_known = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit s, bit va, logic [3:0] ic,
                                logic [63:0] vc, logic [63:0] vp);
        vec_t v;
        v.rst_n = r; v.stall = s; v.valid = va; v.icode = ic;
        v.valc = vc; v.valp = vp;
        v.m_icode = INOP; v.m_cnd = 1'b0; v.m_vala = '0;
        v.w_icode = INOP; v.w_valm = '0; v.w_redir = 1'b0;
        v.has_exp = 1'b0; v.chk_comb = 1'b0;
        v.exp_fpc = '0; v.exp_rpv = 1'b0; v.exp_pred = '0;
        v.exp_cnt = 0; v.exp_ovf = 1'b0;
        return v;
    endfunction

    function automatic vec_t ex(vec_t v, logic [63:0] p, int c, bit o);
        v.has_exp = 1'b1; v.exp_pred = p; v.exp_cnt = c; v.exp_ovf = o;
        return v;
    endfunction

    function automatic vec_t ex_c(vec_t v, logic [63:0] f, bit r,
                                  logic [63:0] p, int c, bit o);
        v = ex(v, p, c, o);
        v.chk_comb = 1'b1; v.exp_fpc = f; v.exp_rpv = r;
        return v;
    endfunction

    // Apply one cycle: drive, check combinational outputs, advance the model,
    // clock, then check registered outputs
    task automatic step(input vec_t v);
        logic [63:0] e_fpc, e_np;
        bit e_rpv, redir_m, redir_w;
        @(negedge clk);
        rst_n                = v.rst_n;
        bus.f_stall_i        = v.stall;
        bus.f_valid_i        = v.valid;
        bus.f_icode_i        = v.icode;
        bus.f_valC_i         = v.valc;
        bus.f_valP_i         = v.valp;
        bus.M_icode_i        = v.m_icode;
        bus.M_Cnd_i          = v.m_cnd;
        bus.M_valA_i         = v.m_vala;
        bus.W_icode_i        = v.w_icode;
        bus.W_valM_i         = v.w_valm;
        bus.W_ret_redirect_i = v.w_redir;
        #1;
        redir_m = (v.m_icode == IJXX) && !v.m_cnd;
        redir_w = (v.w_icode == IRET) && v.w_redir;
        e_fpc = redir_m ? v.m_vala : (redir_w ? v.w_valm : m_pred);
        e_rpv = 1'b0;
        if (v.icode == ICALL || v.icode == IJXX)
            e_np = v.valc;
        else if (v.icode == IRET && m_ras.size() > 0) begin
            e_np = m_ras[$];
            e_rpv = 1'b1;
        end else if (v.icode == IHALT)
            e_np = e_fpc;
        else
            e_np = v.valp;

        if (m_known) begin
            chk("f_pc_o", bus.f_pc_o, e_fpc);
            chk("ret_pred_valid_o", 64'(bus.ret_pred_valid_o), 64'(e_rpv));
        end
        if (v.has_exp && v.chk_comb) begin
            chk("tab_f_pc_o", bus.f_pc_o, v.exp_fpc);
            chk("tab_ret_pred_valid_o", 64'(bus.ret_pred_valid_o), 64'(v.exp_rpv));
        end

        if (!v.rst_n) begin
            m_pred = '0;
            m_ras.delete();
            m_ovf = 1'b0;
            m_known = 1'b1;
        end else begin
            if (!v.stall) m_pred = v.valid ? e_np : e_fpc;
            if (redir_w)
                m_ras.delete();
            else if (!v.stall && v.valid) begin
                if (v.icode == ICALL) begin
                    m_ras.push_back(v.valp);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                end else if (v.icode == IRET && m_ras.size() > 0)
                    void'(m_ras.pop_back());
            end
        end

        @(posedge clk);
        #1;
        if (m_known) begin
            chk("predPC_o", bus.predPC_o, m_pred);
            chk("ras_count_o", 64'(bus.ras_count_o), 64'(m_ras.size()));
            chk("ras_overflow_o", 64'(bus.ras_overflow_o), 64'(m_ovf));
        end
        if (v.has_exp) begin
            chk("tab_predPC_o", bus.predPC_o, v.exp_pred);
            chk("tab_ras_count_o", 64'(bus.ras_count_o), 64'(v.exp_cnt));
            chk("tab_ras_overflow_o", 64'(bus.ras_overflow_o), 64'(v.exp_ovf));
        end
    endtask

    vec_t tab [11];
    vec_t v;

    initial begin
        // Reset, then fall-through, CALL/RET pair, jXX mispredict, empty-RAS RET
        tab[0]  = ex(mk(1'b0, 1'b0, 1'b0, INOP, 64'h0, 64'h0), 64'h0, 0, 1'b0);
        tab[1]  = ex_c(mk(1'b0, 1'b0, 1'b0, INOP, 64'h0, 64'h0), 64'h0, 1'b0, 64'h0, 0, 1'b0);
        tab[2]  = ex_c(mk(1'b1, 1'b0, 1'b1, IOPQ, 64'h0, 64'h2), 64'h0, 1'b0, 64'h2, 0, 1'b0);
        tab[3]  = ex_c(mk(1'b1, 1'b0, 1'b1, IOPQ, 64'h0, 64'h10), 64'h2, 1'b0, 64'h10, 0, 1'b0);
        tab[4]  = ex_c(mk(1'b1, 1'b0, 1'b1, ICALL, 64'h100, 64'h19), 64'h10, 1'b0, 64'h100, 1, 1'b0);
        tab[5]  = ex_c(mk(1'b1, 1'b0, 1'b1, IRET, 64'h0, 64'h101), 64'h100, 1'b1, 64'h19, 0, 1'b0);
        tab[6]  = ex_c(mk(1'b1, 1'b0, 1'b1, IOPQ, 64'h0, 64'h20), 64'h19, 1'b0, 64'h20, 0, 1'b0);
        tab[7]  = ex_c(mk(1'b1, 1'b0, 1'b1, IJXX, 64'h80, 64'h29), 64'h20, 1'b0, 64'h80, 0, 1'b0);
        tab[8]  = ex_c(mk(1'b1, 1'b0, 1'b1, IOPQ, 64'h0, 64'h82), 64'h80, 1'b0, 64'h82, 0, 1'b0);
        v = mk(1'b1, 1'b0, 1'b1, IOPQ, 64'h0, 64'h2b);
        v.m_icode = IJXX; v.m_cnd = 1'b0; v.m_vala = 64'h29;
        tab[9]  = ex_c(v, 64'h29, 1'b0, 64'h2b, 0, 1'b0);
        tab[10] = ex_c(mk(1'b1, 1'b0, 1'b1, IRET, 64'h0, 64'h2d), 64'h2b, 1'b0, 64'h2d, 0, 1'b0);

        for (int i = 0; i < 11; i++) step(tab[i]);

        // Nine CALLs overflow the 8-entry stack; eight RETs pop newest-first
        for (int i = 0; i < 9; i++)
            step(ex(mk(1'b1, 1'b0, 1'b1, ICALL, 64'h300 + 64'(i * 16), 64'h100 + 64'(i)),
                    64'h300 + 64'(i * 16), (i < 8) ? i + 1 : 8, i == 8));
        for (int k = 0; k < 8; k++)
            step(ex_c(mk(1'b1, 1'b0, 1'b1, IRET, 64'h0, 64'h500 + 64'(k)),
                      (k == 0) ? 64'h380 : 64'h108 - 64'(k - 1), 1'b1,
                      64'h108 - 64'(k), 7 - k, 1'b1));
        step(ex_c(mk(1'b1, 1'b0, 1'b1, IRET, 64'h0, 64'h508), 64'h101, 1'b0, 64'h508, 0, 1'b1));

        // Redirect during stall: RAS cleared, predPC held
        step(ex(mk(1'b1, 1'b0, 1'b1, ICALL, 64'h700, 64'h50f), 64'h700, 1, 1'b1));
        v = mk(1'b1, 1'b1, 1'b1, IOPQ, 64'h0, 64'h77);
        v.w_icode = IRET; v.w_redir = 1'b1; v.w_valm = 64'h40;
        step(ex_c(v, 64'h40, 1'b0, 64'h700, 0, 1'b1));
        step(ex(mk(1'b1, 1'b0, 1'b1, IOPQ, 64'h0, 64'h42), 64'h42, 0, 1'b1));

        // Reset mid-sequence with live entries and a pending mispredict
        for (int i = 0; i < 5; i++)
            step(mk(1'b1, 1'b0, 1'b1, ICALL, 64'h600 + 64'(i), 64'h700 + 64'(i)));
        v = mk(1'b0, 1'b1, 1'b1, ICALL, 64'h900, 64'h901);
        v.m_icode = IJXX; v.m_cnd = 1'b0; v.m_vala = 64'h999;
        step(ex(v, 64'h0, 0, 1'b0));
        for (int i = 0; i < 3; i++)
            step(ex_c(mk(1'b1, 1'b0, 1'b1, IHALT, 64'h55, 64'h1), 64'h0, 1'b0, 64'h0, 0, 1'b0));

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [3:0] ic;
            r = int'($urandom_range(0, 9));
            if (r < 3)      ic = ICALL;
            else if (r < 5) ic = IRET;
            else            ic = 4'($urandom_range(0, 15));
            v = mk($urandom_range(0, 63) != 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 5) != 0, ic,
                   {$urandom, $urandom}, {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) begin
                v.m_icode = IJXX; v.m_cnd = 1'b0; v.m_vala = {$urandom, $urandom};
            end else if ($urandom_range(0, 3) == 0) begin
                v.m_icode = IJXX; v.m_cnd = 1'b1; v.m_vala = {$urandom, $urandom};
            end
            if ($urandom_range(0, 11) == 0) begin
                v.w_icode = IRET; v.w_redir = 1'b1; v.w_valm = {$urandom, $urandom};
            end else if ($urandom_range(0, 5) == 0) begin
                v.w_icode = IRET; v.w_valm = {$urandom, $urandom};
            end
            step(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_pc_predictor.md
Name: fetch_pc_predictor

Overview:
- Parametrised next-generation fetch-stage PC unit for the Y86-64 pipeline.
- Owns the F-stage predPC register and selects the fetch PC from predPC, the M-stage jXX mispredict path and the W-stage ret redirect.
- Adds a return-address stack (RAS) so RET targets are predicted instead of always waiting for W_valM.
- Sits between the pipeline control/hazard unit and instruction memory.

Parameters:
- PC_WIDTH, 64, width of every PC/address value.
- RAS_DEPTH, 8, number of RAS entries; power of two, at least 2.
- RAS_PTR_W, 3, log2(RAS_DEPTH); must match RAS_DEPTH.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; synchronous, active-low
- f_stall_i  in  1  hold F stage; predPC and RAS do not update
- f_valid_i  in  1  fetched instruction at f_pc_o is valid (not a bubble, no imem error)
- f_icode_i  in  4  icode of instruction at f_pc_o
- f_valC_i  in  PC_WIDTH  constant word of fetched instruction
- f_valP_i  in  PC_WIDTH  fall-through PC of fetched instruction
- M_icode_i  in  4  M-stage icode
- M_Cnd_i  in  1  M-stage condition result
- M_valA_i  in  PC_WIDTH  M-stage valA (fall-through PC of a jXX)
- W_icode_i  in  4  W-stage icode
- W_valM_i  in  PC_WIDTH  W-stage loaded return address
- W_ret_redirect_i  in  1  from hazard unit: W-stage RET was mispredicted
- f_pc_o  out  PC_WIDTH  selected fetch PC (combinational)
- predPC_o  out  PC_WIDTH  predPC register
- ret_pred_valid_o  out  1  current RET prediction came from a non-empty RAS
- ras_count_o  out  RAS_PTR_W+1  live RAS entries
- ras_overflow_o  out  1  sticky: a push overwrote an entry

Behaviour:
- Reset, checked on clk_i rising edge with rst_n_i=0: predPC_o=0; RAS count=0; top pointer=0; ras_overflow_o=0. Reset overrides stall and any in-flight redirect; entry contents are don't-care.
- f_pc_o selection, in priority order:
  - (M_icode_i==IJXX && M_Cnd_i==0) -> M_valA_i
  - (W_icode_i==IRET && W_ret_redirect_i) -> W_valM_i
  - otherwise -> predPC_o
- Next-PC prediction, combinational from f_icode_i:
  - ICALL, IJXX -> f_valC_i
  - IRET with RAS non-empty -> RAS top, ret_pred_valid_o=1
  - IRET with RAS empty -> f_valP_i, ret_pred_valid_o=0; the hazard unit must later assert W_ret_redirect_i
  - IHALT -> f_pc_o (PC holds; never jumps to 0)
  - all others -> f_valP_i
  - ret_pred_valid_o=0 whenever f_icode_i!=IRET.
- predPC update, one-cycle latency, applies when rst_n_i=1 and f_stall_i=0:
  - f_valid_i=1 -> predPC <= prediction
  - f_valid_i=0 -> predPC <= f_pc_o, so a redirect is never lost
- f_stall_i=1: predPC and the RAS hold. f_pc_o still reflects redirects combinationally.
- RAS update, only when f_stall_i=0, f_valid_i=1 and no W_ret_redirect_i:
  - ICALL -> push f_valP_i
  - IRET with count>0 -> pop
  - IRET with count==0 -> no change
- RAS full (count==RAS_DEPTH) and push: circular overwrite of the oldest entry; count stays RAS_DEPTH; ras_overflow_o <= 1 until reset.
- Pointer arithmetic is modulo RAS_DEPTH; the pointer wraps 7->0 at the default depth.
- W_ret_redirect_i=1 (with W_icode_i==IRET): RAS cleared, count <= 0, regardless of stall or the fetched icode. The fetched instruction's push/pop is dropped that cycle; predPC still follows the update rules above.
- jXX mispredict does not repair the RAS. Wrong-path push/pop damage is recovered only via a later W_ret_redirect_i.
- Unknown icode: treated as fall-through, with no RAS action.
- All width arithmetic is PC_WIDTH bits; no PC truncation or extension inside the block.

Test Plan:
1. Reset, then release with f_valid_i=1, f_icode_i=IOPQ, f_valP_i=0x2 -> f_pc_o=0 in the reset cycle; next cycle predPC_o=0x2; ras_count_o=0; ras_overflow_o=0.
2. Fetch ICALL at 0x10 (valC=0x100, valP=0x19), then IRET at 0x100 -> predPC=0x100, count=1; then predPC=0x19, ret_pred_valid_o=1, count=0.
3. IJXX at 0x20 (valC=0x80, valP=0x29) predicts 0x80; two cycles later M_icode=IJXX, M_Cnd=0, M_valA=0x29 -> f_pc_o=0x29 that cycle; predPC advances from 0x29's fall-through.
4. 9 consecutive ICALLs with valP=0x100..0x108 (RAS_DEPTH=8) -> count=8, ras_overflow_o=1; 8 IRETs pop 0x108..0x101; the 9th IRET has ret_pred_valid_o=0 and predicts its own valP.
5. Stall with redirect: f_stall_i=1 while W_icode=IRET, W_ret_redirect_i=1, W_valM=0x40 -> f_pc_o=0x40, predPC unchanged, RAS cleared; release stall, fetch IOPQ valP=0x42 -> predPC=0x42.
6. Reset asserted mid-sequence with count=5 and a pending M mispredict -> next cycle predPC=0, count=0, overflow=0; IHALT at 0x0 -> predPC holds 0 for 3 cycles.
